// File: rtl/nibble_add_sched.sv
// Round-robin scheduler that shares one external 4-bit adder between two
// requesters, sequencing WIDTH-bit additions one nibble per cycle.
module nibble_add_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout
);

  localparam int NIB = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             ptr;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic             grant0;
  logic             grant1;

  // ptr == 0 favours req0 when both requesters are valid
  assign grant0 = (state == IDLE) && req0_valid && (!req1_valid || !ptr);
  assign grant1 = (state == IDLE) && req1_valid && (!req0_valid || ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    res_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 || grant1) state_nxt = RUN;
      end
      RUN: begin
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state == RUN) begin
      for (int i = 0; i < NIB; i++) begin
        if (idx == IDX_W'(i)) begin
          add_a = op_a[4*i +: 4];
          add_b = op_b[4*i +: 4];
        end
      end
      add_cin = carry;
    end
  end

  // Operand latch at the handshake, then one nibble of sum per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= 1'b0;
      idx      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      res_id   <= 1'b0;
      res_sum  <= '0;
      res_cout <= 1'b0;
    end else begin
      if (grant0 || grant1) begin
        op_a   <= grant1 ? req1_a : req0_a;
        op_b   <= grant1 ? req1_b : req0_b;
        carry  <= grant1 ? req1_cin : req0_cin;
        res_id <= grant1;
        ptr    <= ~grant1;
        idx    <= '0;
      end else if (state == RUN) begin
        for (int i = 0; i < NIB; i++) begin
          if (idx == IDX_W'(i)) res_sum[4*i +: 4] <= add_sum;
        end
        carry <= add_cout;
        if (idx == LAST) begin
          res_cout <= add_cout;
          idx      <= '0;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_add_sched.sv
// Directed bench for nibble_add_sched: a WIDTH=16 instance and a WIDTH=4
// instance, each paired with a behavioural 4-bit adder.
module tb_nibble_add_sched;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_cin;
  logic        req1_valid, req1_ready, req1_cin;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        res_valid, res_ready, res_id, res_cout;
  logic [15:0] res_sum;

  logic        w4_req0_valid, w4_req0_ready, w4_req0_cin;
  logic        w4_req1_valid, w4_req1_ready, w4_req1_cin;
  logic [3:0]  w4_req0_a, w4_req0_b, w4_req1_a, w4_req1_b;
  logic [3:0]  w4_add_a, w4_add_b, w4_add_sum;
  logic        w4_add_cin, w4_add_cout;
  logic        w4_res_valid, w4_res_ready, w4_res_id, w4_res_cout;
  logic [3:0]  w4_res_sum;

  int errors = 0;
  int checks = 0;

  assign {add_cout, add_sum}       = 5'(add_a) + 5'(add_b) + 5'(add_cin);
  assign {w4_add_cout, w4_add_sum} = 5'(w4_add_a) + 5'(w4_add_b) + 5'(w4_add_cin);

  nibble_add_sched #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_sum(res_sum), .res_cout(res_cout)
  );

  nibble_add_sched #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(w4_req0_valid), .req0_ready(w4_req0_ready), .req0_a(w4_req0_a), .req0_b(w4_req0_b), .req0_cin(w4_req0_cin),
    .req1_valid(w4_req1_valid), .req1_ready(w4_req1_ready), .req1_a(w4_req1_a), .req1_b(w4_req1_b), .req1_cin(w4_req1_cin),
    .add_a(w4_add_a), .add_b(w4_add_b), .add_cin(w4_add_cin), .add_sum(w4_add_sum), .add_cout(w4_add_cout),
    .res_valid(w4_res_valid), .res_ready(w4_res_ready), .res_id(w4_res_id), .res_sum(w4_res_sum), .res_cout(w4_res_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic clear_inputs();
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_cin = 0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_cin = 0;
    res_ready = 1;
    w4_req0_valid = 0; w4_req0_a = '0; w4_req0_b = '0; w4_req0_cin = 0;
    w4_req1_valid = 0; w4_req1_a = '0; w4_req1_b = '0; w4_req1_cin = 0;
    w4_res_ready = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    clear_inputs();
    #1;
    checks++;
    if ({req0_ready, req1_ready, add_a, add_b, add_cin, res_valid, res_id, res_sum, res_cout} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs16: got ready=%b%b add=%h/%h/%b res=%b/%b/%h/%b required all 0",
               req0_ready, req1_ready, add_a, add_b, add_cin, res_valid, res_id, res_sum, res_cout);
    end
    checks++;
    if ({w4_req0_ready, w4_req1_ready, w4_add_a, w4_add_b, w4_add_cin, w4_res_valid, w4_res_id, w4_res_sum, w4_res_cout} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs4: got add=%h/%h res=%b/%h/%b required all 0",
               w4_add_a, w4_add_b, w4_res_valid, w4_res_sum, w4_res_cout);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_basic();
    logic [3:0] exp_a [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    logic [3:0] exp_b [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    do_reset();
    req0_valid = 1; req0_a = 16'h1234; req0_b = 16'h4321; req0_cin = 0;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL basic_grant: got ready=%b%b required 10", req0_ready, req1_ready);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req0_valid = 0; req0_a = 16'hFFFF; req0_b = 16'hFFFF;
      #1;
      checks++;
      if ({res_valid, req0_ready, add_a, add_b, add_cin} !== {2'b00, exp_a[k], exp_b[k], 1'b0}) begin
        errors++;
        $display("FAIL basic_run%0d: got valid=%b ready=%b add=%h/%h/%b required 0 0 %h/%h/0",
                 k, res_valid, req0_ready, add_a, add_b, add_cin, exp_a[k], exp_b[k]);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({res_valid, res_id, res_cout, res_sum} !== {3'b100, 16'h5555}) begin
      errors++;
      $display("FAIL basic_result: got valid=%b id=%b cout=%b sum=%h required 1 0 0 5555",
               res_valid, res_id, res_cout, res_sum);
    end
    @(negedge clk);
    #1;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL basic_release: got res_valid=%b required 0", res_valid);
    end
  endtask

  task automatic test_carry_chain();
    do_reset();
    req0_valid = 1; req0_a = 16'hFFFF; req0_b = 16'h0000; req0_cin = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req0_valid = 0;
      #1;
      checks++;
      if (add_cin !== 1'b1) begin
        errors++; $display("FAIL carry_cin%0d: got add_cin=%b required 1", k, add_cin);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({res_valid, res_cout, res_sum} !== {2'b11, 16'h0000}) begin
      errors++;
      $display("FAIL carry_result: got valid=%b cout=%b sum=%h required 1 1 0000", res_valid, res_cout, res_sum);
    end
  endtask

  task automatic test_back_to_back();
    int gid [4];
    int gcyc [4];
    int ng = 0;
    int nres = 0;
    do_reset();
    req0_valid = 1; req0_a = 16'h0001; req0_b = 16'h0002; req0_cin = 0;
    req1_valid = 1; req1_a = 16'h8000; req1_b = 16'h8000; req1_cin = 1;
    res_ready = 1;
    for (int c = 0; c < 26; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (req0_ready || req1_ready) begin
        if (ng < 4) begin
          gid[ng] = int'(req1_ready);
          gcyc[ng] = c;
        end
        ng++;
      end
      if (res_valid) begin
        checks++;
        if (nres % 2 == 0) begin
          if ({res_id, res_cout, res_sum} !== {2'b00, 16'h0003}) begin
            errors++;
            $display("FAIL b2b_result%0d: got id=%b cout=%b sum=%h required 0 0 0003", nres, res_id, res_cout, res_sum);
          end
        end else begin
          if ({res_id, res_cout, res_sum} !== {2'b11, 16'h0001}) begin
            errors++;
            $display("FAIL b2b_result%0d: got id=%b cout=%b sum=%h required 1 1 0001", nres, res_id, res_cout, res_sum);
          end
        end
        nres++;
      end
    end
    checks++;
    if (ng < 4) begin
      errors++; $display("FAIL b2b_grant_count: got %0d required at least 4", ng);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (gid[k] != (k % 2) || gcyc[k] != 6 * k) begin
          errors++;
          $display("FAIL b2b_grant%0d: got id=%0d cycle=%0d required id=%0d cycle=%0d", k, gid[k], gcyc[k], k % 2, 6 * k);
        end
      end
    end
    checks++;
    if (nres != 4) begin
      errors++; $display("FAIL b2b_result_count: got %0d required 4", nres);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req0_valid = 1; req0_a = 16'h00FF; req0_b = 16'h0001; req0_cin = 0;
    req1_valid = 1; req1_a = 16'h0010; req1_b = 16'h0020; req1_cin = 0;
    res_ready = 0;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL bp_grant: got ready=%b%b required 10", req0_ready, req1_ready);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req0_valid = 0;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({res_valid, res_id, res_cout, res_sum, req0_ready, req1_ready} !== {3'b100, 16'h0100, 2'b00}) begin
        errors++;
        $display("FAIL bp_hold%0d: got valid=%b id=%b cout=%b sum=%h ready=%b%b required 1 0 0 0100 00",
                 k, res_valid, res_id, res_cout, res_sum, req0_ready, req1_ready);
      end
    end
    @(negedge clk);
    res_ready = 1;
    #1;
    checks++;
    if ({res_valid, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL bp_release: got valid=%b req1_ready=%b required 1 0", res_valid, req1_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({res_valid, req0_ready, req1_ready} !== 3'b001) begin
      errors++;
      $display("FAIL bp_next_grant: got valid=%b ready=%b%b required 0 01", res_valid, req0_ready, req1_ready);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req1_valid = 0;
    end
    #1;
    checks++;
    if ({res_valid, res_id, res_cout, res_sum} !== {3'b110, 16'h0030}) begin
      errors++;
      $display("FAIL bp_second_result: got valid=%b id=%b cout=%b sum=%h required 1 1 0 0030",
               res_valid, res_id, res_cout, res_sum);
    end
  endtask

  task automatic test_reset_mid_run();
    int late_valid = 0;
    do_reset();
    req0_valid = 1; req0_a = 16'h1234; req0_b = 16'h4321; req0_cin = 0;
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    #1;
    checks++;
    if ({add_a, add_b, res_sum} !== {4'h3, 4'h2, 16'h0005}) begin
      errors++;
      $display("FAIL rst_pre: got add=%h/%h sum=%h required 3/2 0005", add_a, add_b, res_sum);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, add_a, add_b, add_cin, res_valid, res_id, res_sum, res_cout} !== 29'd0) begin
      errors++;
      $display("FAIL rst_mid_run: got add=%h/%h/%b res=%b/%b/%h/%b required all 0",
               add_a, add_b, add_cin, res_valid, res_id, res_sum, res_cout);
    end
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (res_valid) late_valid++;
    end
    checks++;
    if (late_valid != 0) begin
      errors++; $display("FAIL rst_no_result: got %0d valid cycles required 0", late_valid);
    end
    @(negedge clk);
    req0_valid = 1; req1_valid = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL rst_fresh_grant: got ready=%b%b required 10", req0_ready, req1_ready);
    end
  endtask

  task automatic test_width4();
    do_reset();
    w4_req0_valid = 1; w4_req0_a = 4'h9; w4_req0_b = 4'h8; w4_req0_cin = 0;
    #1;
    checks++;
    if (w4_req0_ready !== 1'b1) begin
      errors++; $display("FAIL w4_grant: got ready=%b required 1", w4_req0_ready);
    end
    @(negedge clk);
    w4_req0_valid = 0;
    #1;
    checks++;
    if ({w4_res_valid, w4_add_a, w4_add_b} !== {1'b0, 4'h9, 4'h8}) begin
      errors++;
      $display("FAIL w4_run: got valid=%b add=%h/%h required 0 9/8", w4_res_valid, w4_add_a, w4_add_b);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({w4_res_valid, w4_res_id, w4_res_cout, w4_res_sum} !== {3'b101, 4'h1}) begin
      errors++;
      $display("FAIL w4_result: got valid=%b id=%b cout=%b sum=%h required 1 0 1 1",
               w4_res_valid, w4_res_id, w4_res_cout, w4_res_sum);
    end
    @(negedge clk);
    #1;
    checks++;
    if (w4_res_valid !== 1'b0) begin
      errors++; $display("FAIL w4_release: got valid=%b required 0", w4_res_valid);
    end
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_basic();
    test_carry_chain();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    test_width4();
    do_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
